// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding and the
// instruction-fetch state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0;

  typedef enum logic [2:0] {
    S_ISSUE,
    S_REQ,
    S_HOLD,
    S_DRAIN,
    S_FAULT
  } if_state_e;

endpackage

// File: rtl/if_watchdog.sv
// Ack watchdog for the fetch stage: counts stalled request cycles
// and flags the cycle whose increment would reach TIMEOUT.
module if_watchdog
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expired = count && !clear &&
                   (cnt_q == W'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count && cnt_q != W'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding imem read, held for decode.
// Define IF_TIMEOUT_EN to add the ack watchdog and sticky FAULT state.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_halt,
  input  logic            flush,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  output logic            fault
);

  if_state_e state_q, state_d;

  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] ipc_q, ipc_d;
  logic            fault_q, fault_d;

  logic ack;
  logic wd_exp;

  // an ack with no request outstanding is not a response
  assign ack = req_q && imem_ack;

`ifdef IF_TIMEOUT_EN
  logic wd_clear;
  logic wd_count;

  assign wd_clear = (state_q == S_ISSUE) || ack;
  assign wd_count = ((state_q == S_REQ) ||
                     (state_q == S_DRAIN)) && !ack;

  if_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst_n   (Reset),
    .clear   (wd_clear),
    .count   (wd_count),
    .expired (wd_exp)
  );
`else
  assign wd_exp = 1'b0;
`endif

  assign pc_halt = !Reset ||
                   (state_q == S_FAULT) ||
                   !(((state_q == S_HOLD) && inst_ready) ||
                     flush);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;
    unique case (state_q)
      S_ISSUE: begin
        addr_d  = pc_in;
        req_d   = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        if (ack) begin
          req_d = 1'b0;
          if (flush) begin
            state_d = S_ISSUE;
          end else begin
            inst_d  = imem_rdata;
            ipc_d   = addr_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else if (wd_exp) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_FAULT;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (inst_ready || flush) begin
          valid_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (ack) begin
          req_d   = 1'b0;
          state_d = S_ISSUE;
        end else if (wd_exp) begin
          fault_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_FAULT;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_ISSUE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      inst_q  <= NOP;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign inst_pc    = ipc_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: cycle vector table, then scoreboarded runs
// against a PC register and a variable-latency memory model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        Reset;
  logic [31:0] pc_in;
  logic        pc_halt;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fault;

  always #5 clk = ~clk;

  inst_fetch #(
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .pc_in      (pc_in),
    .pc_halt    (pc_halt),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .fault      (fault)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        fl;
    logic        ack;
    logic        rdy;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        halt;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;

  function automatic vec_t mkv(
    input logic fl, ack, rdy,
    input logic [31:0] pc, rd,
    input logic halt, req,
    input logic [31:0] addr,
    input logic vld,
    input logic [31:0] ins, ipc);
    vec_t r;
    r.fl = fl; r.ack = ack; r.rdy = rdy;
    r.pc = pc; r.rd = rd; r.halt = halt;
    r.req = req; r.addr = addr; r.vld = vld;
    r.ins = ins; r.ipc = ipc;
    return r;
  endfunction

  localparam logic [31:0] IA = 32'h1111_0000;
  localparam logic [31:0] IB = 32'h2222_0004;
  localparam logic [31:0] IC = 32'h3333_0400;

  vec_t tbl[19];

  // memory / PC environment and scoreboard
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] pc_m;
  int          wait_cfg;
  int          wcnt;
  int          rlen;
  bit          killed;
  int          consumed;
  logic        prev_rq, prev_ack, prev_v, prev_tk;
  logic [31:0] prev_ad, prev_ins;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  task automatic do_reset();
    Reset = 1'b0;
    flush = 1'b0;
    inst_ready = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    pc_in = '0;
    pc_m = '0;
    wcnt = 0;
    rlen = 0;
    killed = 1'b0;
    consumed = 0;
    exp_q.delete();
    prev_rq = 0; prev_ack = 0;
    prev_v = 0; prev_tk = 0;
    prev_ad = '0; prev_ins = '0;
    repeat (2) @(negedge clk);
    Reset = 1'b1;
  endtask

  // one clock of the environment, entered and left at a negedge
  task automatic cyc(input logic fl,
                     input logic rdy,
                     input logic [31:0] tgt);
    logic h, rq, v;
    logic [31:0] ad;
    ent_t e;
    flush = fl;
    inst_ready = rdy;
    pc_in = pc_m;
    imem_ack = imem_req && (wcnt >= wait_cfg);
    imem_rdata = imem_ack ? memf(imem_addr) : 32'h0;
    #1;
    h = pc_halt;
    rq = imem_req;
    ad = imem_addr;
    v = inst_valid;
    if (fl) chk("halt_flush", h, 0);
    else if (v && rdy) chk("halt_take", h, 0);
    else chk("halt_hold", h, 1);
    if (rq && prev_rq && !prev_ack)
      chk("addr_stable", ad, prev_ad);
    if (v && prev_v && !prev_tk)
      chk("inst_stable", inst, prev_ins);
    if (v && (rdy || fl)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_inst", inst_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        if (!fl) begin
          chk("sb_inst", inst, e.d);
          chk("sb_pc", inst_pc, e.a);
          consumed++;
        end
      end
    end
    if (rq && imem_ack) begin
      chk("req_len", rlen + 1, wait_cfg + 1);
      if (!killed && !fl) exp_q.push_back({ad, memf(ad)});
      killed = 1'b0;
    end else if (rq && fl) begin
      killed = 1'b1;
    end
    @(posedge clk);
    if (fl) pc_m = tgt;
    else if (!h) pc_m = pc_m + 32'd4;
    wcnt = (rq && !imem_ack) ? wcnt + 1 : 0;
    rlen = (rq && !imem_ack) ? rlen + 1 : 0;
    prev_rq = rq;
    prev_ack = imem_ack;
    prev_ad = ad;
    prev_v = v;
    prev_tk = v && (rdy || fl);
    prev_ins = inst;
    @(negedge clk);
  endtask

  initial begin
    //          fl ack rdy pc     rd           halt req addr   vld ins  ipc
    tbl[0]  = mkv(0, 0, 1, 32'h0,  32'h0,        1, 1, 32'h0,  0, 32'h0, 32'h0);
    tbl[1]  = mkv(0, 1, 1, 32'h0,  IA,           1, 0, 32'h0,  1, IA, 32'h0);
    tbl[2]  = mkv(0, 0, 1, 32'h0,  32'h0,        0, 0, 32'h0,  0, IA, 32'h0);
    tbl[3]  = mkv(0, 0, 1, 32'h4,  32'h0,        1, 1, 32'h4,  0, IA, 32'h0);
    tbl[4]  = mkv(0, 1, 0, 32'h4,  IB,           1, 0, 32'h4,  1, IB, 32'h4);
    tbl[5]  = mkv(0, 0, 0, 32'h4,  32'h0,        1, 0, 32'h4,  1, IB, 32'h4);
    tbl[6]  = mkv(0, 1, 0, 32'h4,  32'hFFFF_FFFF, 1, 0, 32'h4, 1, IB, 32'h4);
    tbl[7]  = mkv(0, 0, 0, 32'h4,  32'h0,        1, 0, 32'h4,  1, IB, 32'h4);
    tbl[8]  = mkv(0, 0, 0, 32'h4,  32'h0,        1, 0, 32'h4,  1, IB, 32'h4);
    tbl[9]  = mkv(1, 0, 1, 32'h4,  32'h0,        0, 0, 32'h4,  0, IB, 32'h4);
    tbl[10] = mkv(0, 1, 0, 32'h80, 32'hDEAD,     1, 1, 32'h80, 0, IB, 32'h4);
    tbl[11] = mkv(1, 0, 0, 32'h80, 32'h0,        0, 1, 32'h80, 0, IB, 32'h4);
    tbl[12] = mkv(1, 0, 0, 32'h200, 32'h0,       0, 1, 32'h80, 0, IB, 32'h4);
    tbl[13] = mkv(0, 1, 1, 32'h300, 32'hBAD,     1, 0, 32'h80, 0, IB, 32'h4);
    tbl[14] = mkv(0, 0, 0, 32'h300, 32'h0,       1, 1, 32'h300, 0, IB, 32'h4);
    tbl[15] = mkv(1, 1, 0, 32'h300, 32'hBAD2,    0, 0, 32'h300, 0, IB, 32'h4);
    tbl[16] = mkv(0, 0, 0, 32'h400, 32'h0,       1, 1, 32'h400, 0, IB, 32'h4);
    tbl[17] = mkv(0, 1, 0, 32'h400, IC,          1, 0, 32'h400, 1, IC, 32'h400);
    tbl[18] = mkv(0, 0, 1, 32'h400, 32'h0,       0, 0, 32'h400, 0, IC, 32'h400);

    Reset = 1'b0;
    flush = 1'b0;
    inst_ready = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    pc_in = 32'h1234;
    #3;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_ipc", inst_pc, 0);
    chk("rst_fault", fault, 0);
    chk("rst_halt", pc_halt, 1);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      flush = tbl[i].fl;
      imem_ack = tbl[i].ack;
      inst_ready = tbl[i].rdy;
      pc_in = tbl[i].pc;
      imem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_halt", i), pc_halt, tbl[i].halt);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_req", i), imem_req, tbl[i].req);
      chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_vld", i), inst_valid, tbl[i].vld);
      chk($sformatf("v%0d_inst", i), inst, tbl[i].ins);
      chk($sformatf("v%0d_ipc", i), inst_pc, tbl[i].ipc);
      chk($sformatf("v%0d_fault", i), fault, 0);
      @(negedge clk);
    end

    // zero-wait stream, decode always ready
    do_reset();
    wait_cfg = 0;
    for (int c = 0; c < 12; c++) cyc(0, 1, 0);
    chk("A_count", consumed, 4);
    chk("A_pc", pc_m, 32'h10);
    chk("A_q", exp_q.size(), 0);

    // five wait cycles
    do_reset();
    wait_cfg = 5;
    for (int c = 0; c < 8; c++) cyc(0, 1, 0);
    chk("B_count", consumed, 1);
    chk("B_pc", pc_m, 32'h4);
    chk("B_q", exp_q.size(), 0);

    // flush on the second wait cycle, redirect to 0x40
    do_reset();
    wait_cfg = 5;
    for (int c = 1; c <= 15; c++) cyc(c == 3, 1, 32'h40);
    chk("C_count", consumed, 1);
    chk("C_pc", pc_m, 32'h44);
    chk("C_q", exp_q.size(), 0);

    // held 4 cycles, then flush and ready together
    do_reset();
    wait_cfg = 0;
    for (int c = 1; c <= 10; c++)
      cyc(c == 7, !(c >= 3 && c <= 6), 32'h80);
    chk("D_count", consumed, 1);
    chk("D_pc", pc_m, 32'h84);
    chk("D_q", exp_q.size(), 0);

    // asynchronous reset in the middle of a request
    do_reset();
    wait_cfg = 10;
    pc_m = 32'h44;
    for (int c = 0; c < 3; c++) cyc(0, 1, 0);
    chk("E_pre_req", imem_req, 1);
    chk("E_pre_addr", imem_addr, 32'h44);
    #2;
    Reset = 1'b0;
    #1;
    chk("E_req", imem_req, 0);
    chk("E_addr", imem_addr, 0);
    chk("E_valid", inst_valid, 0);
    chk("E_inst", inst, 0);
    chk("E_halt", pc_halt, 1);
    @(negedge clk);

    // ack never (or very late) arrives
    do_reset();
`ifdef IF_TIMEOUT_EN
    wait_cfg = 1000;
    for (int c = 0; c < 8; c++) cyc(0, 1, 0);
    chk("F_fault_early", fault, 0);
    chk("F_req_early", imem_req, 1);
    cyc(0, 1, 0);
    chk("F_fault", fault, 1);
    chk("F_req", imem_req, 0);
    for (int c = 0; c < 4; c++) begin
      flush = 1'b1;
      inst_ready = 1'b1;
      imem_ack = 1'b1;
      #1;
      chk("F_halt", pc_halt, 1);
      chk("F_sticky", fault, 1);
      chk("F_noreq", imem_req, 0);
      chk("F_novalid", inst_valid, 0);
      @(posedge clk);
      @(negedge clk);
    end
`else
    wait_cfg = 12;
    for (int c = 0; c < 12; c++) cyc(0, 1, 0);
    chk("F_fault", fault, 0);
    chk("F_req", imem_req, 1);
    for (int c = 0; c < 3; c++) cyc(0, 1, 0);
    chk("F_count", consumed, 1);
    chk("F_q", exp_q.size(), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage sitting directly downstream of the program counter register. Takes the current PC value, issues a single outstanding read to instruction memory over a req/ack handshake, and holds the returned word for decode. While a fetch is in progress it drives the PC's halt input so the PC holds. On a redirect (branch/jump) flush it discards any in-flight or held instruction.

## Interface
- `TIMEOUT`, 64: ack watchdog limit in cycles (used only with `IF_TIMEOUT_EN`).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `pc_in`  in  32  current PC from the PC register.
- `pc_halt`  out  1  to the PC halt input; 1 = PC holds, 0 = PC loads its next value this edge.
- `flush`  in  1  redirect pulse; the PC loads the redirect target on the same edge.
- `imem_req`  out  1  memory read request (registered).
- `imem_addr`  out  32  memory read address (registered).
- `imem_ack`  in  1  read complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  read data.
- `inst_valid`  out  1  `inst` / `inst_pc` valid for decode.
- `inst`  out  32  fetched instruction.
- `inst_pc`  out  32  address the instruction was fetched from.
- `inst_ready`  in  1  decode accepts the instruction this cycle.
- `fault`  out  1  sticky memory timeout flag (0 when `IF_TIMEOUT_EN` is off).

## Operation
- States: ISSUE, REQ, HOLD, DRAIN, and FAULT (FAULT only with `IF_TIMEOUT_EN`).
- ISSUE: on the next edge, `imem_addr` <= `pc_in`, `imem_req` <= 1, go to REQ.
- REQ: `imem_req` = 1 and `imem_addr` stay stable until `imem_ack`.
  - ack without flush: `inst` <= `imem_rdata`, `inst_pc` <= `imem_addr`, `inst_valid` <= 1, `imem_req` <= 0, go to HOLD.
  - ack with flush: discard the data, `imem_req` <= 0, go to ISSUE.
  - flush without ack: go to DRAIN. The request is never withdrawn.
- HOLD: `inst_valid` = 1 and outputs stay stable.
  - `inst_ready` or flush: `inst_valid` <= 0, go to ISSUE.
- DRAIN: `imem_req` stays 1 with the old address. On ack, discard the data, `imem_req` <= 0, go to ISSUE. A further flush in DRAIN stays in DRAIN.
- `pc_halt` is combinational: 0 when (HOLD and `inst_ready`) or `flush` (except in FAULT); 1 otherwise. The PC therefore advances exactly once per consumed instruction or redirect.
- Simultaneous flush and `inst_ready` in HOLD: treated as flush, with a single PC update.
- Reset (asynchronous, any state, including mid-request): state ISSUE, `imem_req` 0, `imem_addr` 0, `inst_valid` 0, `inst` 0, `inst_pc` 0, `fault` 0. `pc_halt` reads 1 during reset.

## Timing
- With a zero-wait memory (ack in the first REQ cycle) and decode always ready, throughput is one instruction per 3 cycles: ISSUE, REQ, HOLD.
- Latency from leaving ISSUE to `inst_valid` rising is 1 + (memory wait cycles) edges.
- Address is sampled in ISSUE, so `pc_in` must already reflect the PC update made at the previous HOLD/flush edge. This holds because the PC loads on that same edge.
- `imem_rdata` is sampled only in a cycle where `imem_req` and `imem_ack` are both 1. `imem_ack` seen while `imem_req` is 0 is ignored.

## Configuration
- `IF_TIMEOUT_EN` defined: a counter increments each cycle in REQ or DRAIN with `imem_ack` 0, and clears on ack or on entering ISSUE.
  - When it reaches `TIMEOUT`, the next edge sets `fault` = 1, `imem_req` = 0 and enters FAULT.
  - FAULT holds `pc_halt` = 1 and ignores flush, ack and ready. Only reset exits it.
- `IF_TIMEOUT_EN` undefined: no counter and no FAULT state; the block waits indefinitely; `fault` is tied to 0.

## Structure
- The shared package `cpu_pkg` holds the fetch-state enum, the word/address width constant (32) and the NOP encoding (32'h0).
- The counter is a sub-module, `if_watchdog`: clear/count/expired with width $clog2(TIMEOUT+1). It is instantiated only under `IF_TIMEOUT_EN`.

## Test plan
- Zero-wait memory, `pc_in` = 0x0, then 0x4, `inst_ready` held 1: `imem_addr` 0x0 then 0x4, `inst_valid` every 3rd cycle, `pc_halt` low exactly one cycle per instruction.
- Memory ack delayed 5 cycles: `imem_req`/`imem_addr` stable for 6 cycles, `pc_halt` 1 throughout, `inst` = returned data with `inst_pc` 0x0.
- Flush on cycle 2 of a 5-cycle wait, PC moves to 0x40: DRAIN holds address 0x0 until ack, data discarded, next request to 0x40, `inst_valid` never pulses for 0x0.
- HOLD with `inst_ready` 0 for 4 cycles, then flush and ready together: `inst` stable, a single `pc_halt`=0 cycle, the next fetch is the redirect target.
- `Reset` asserted mid-REQ: outputs return to reset values immediately, with no clock edge needed.
- `IF_TIMEOUT_EN`, `TIMEOUT` = 8, ack never arrives: `fault` rises after 8 REQ cycles, `imem_req` drops, `pc_halt` stays 1 until reset.
